fill_span_engine: RTL



---
 rtl/fill_span_engine_pkg.sv | 22 ++
 rtl/fill_span_engine_if.sv | 41 ++++
 rtl/fill_span_engine_x_counter.sv | 41 ++++
 rtl/fill_span_engine.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fill_span_engine_pkg.sv
// ============================================================================
// Module      : fill_pkg
// Description : Shared fill types and default raster constants for the
//               fill controller and span engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fill_pkg;

    localparam int c_h_res = 640;
    localparam int c_v_res = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/fill_span_engine_if.sv
// ============================================================================
// Module      : fill_span_engine_if
// Description : Fill handshake and frame-buffer write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fill_span_engine_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 8
);
    logic               row_start;
    logic [Y_W-1:0]     y_top;
    logic [Y_W-1:0]     y_bot;
    logic               fill_start;
    logic [X_W-1:0]     x_a;
    logic [X_W-1:0]     x_b;
    logic [COLOR_W-1:0] color;
    logic               wr_ready;
    logic               wr_valid;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic [Y_W-1:0]     cur_y;
    logic               fill_done;
    logic               all_finish;

    // Environment side: fill controller plus frame-buffer arbiter.
    modport master (
        output row_start, y_top, y_bot, fill_start, x_a, x_b, color, wr_ready,
        input  wr_valid, pix_x, pix_y, pix_color, cur_y, fill_done, all_finish
    );

    modport slave (
        input  row_start, y_top, y_bot, fill_start, x_a, x_b, color, wr_ready,
        output wr_valid, pix_x, pix_y, pix_color, cur_y, fill_done, all_finish
    );
endinterface

`default_nettype wire

// File: rtl/fill_span_engine_x_counter.sv
// ============================================================================
// Module      : fill_x_counter
// Description : Loadable span x counter with terminal compare against xr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_x_counter #(
    parameter int X_W = 10
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           i_load,
    input  wire logic [X_W-1:0] i_xl,
    input  wire logic [X_W-1:0] i_xr,
    input  wire logic           i_en,
    output logic      [X_W-1:0] o_x,
    output logic                o_last
);

    logic [X_W-1:0] r_x;
    logic [X_W-1:0] r_xr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x  <= '0;
            r_xr <= '0;
        end else if (i_load) begin
            r_x  <= i_xl;
            r_xr <= i_xr;
        end else if (i_en) begin
            r_x  <= r_x + X_W'(1);
        end
    end

    assign o_x    = r_x;
    assign o_last = (r_x == r_xr);

endmodule

`default_nettype wire

// File: rtl/fill_span_engine.sv
// ============================================================================
// Module      : fill_span_engine
// Description : Responder side of the polygon fill handshake; streams one
//               pixel write per x of the current row's span.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_span_engine
    import fill_pkg::*;
#(
    parameter int H_RES   = c_h_res,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fill_span_engine_if.slave bus
);

    localparam logic [X_W-1:0] c_x_max = X_W'(H_RES - 1);

    fill_state_t        r_state;
    logic               r_wr_valid;
    logic [Y_W-1:0]     r_pix_y;
    logic [COLOR_W-1:0] r_pix_color;
    logic [Y_W-1:0]     r_cur_y;
    logic [Y_W-1:0]     r_y_end;
    logic               r_fill_done;
    logic               r_all_finish;

    logic [X_W-1:0]     w_xl;
    logic [X_W-1:0]     w_xhi;
    logic [X_W-1:0]     w_xr;
    logic               w_empty;
    logic [Y_W-1:0]     w_y_lo;
    logic [Y_W-1:0]     w_y_hi;
    logic               w_accept_fill;
    logic               w_load;
    logic               w_inc;
    logic [X_W-1:0]     w_x;
    logic               w_last;

    assign w_xl    = (bus.x_a < bus.x_b) ? bus.x_a : bus.x_b;
    assign w_xhi   = (bus.x_a < bus.x_b) ? bus.x_b : bus.x_a;
    assign w_xr    = (w_xhi > c_x_max) ? c_x_max : w_xhi;
    assign w_empty = (w_xl > c_x_max);
    assign w_y_lo  = (bus.y_top < bus.y_bot) ? bus.y_top : bus.y_bot;
    assign w_y_hi  = (bus.y_top < bus.y_bot) ? bus.y_bot : bus.y_top;

    // row_start has priority, so a simultaneous fill_start is dropped.
    assign w_accept_fill = (r_state == ST_IDLE) && !bus.row_start && bus.fill_start;
    assign w_load        = w_accept_fill && !w_empty;
    assign w_inc         = (r_state == ST_WRITE) && bus.wr_ready && !w_last;

    fill_x_counter #(
        .X_W (X_W)
    ) u_x_counter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_xl   (w_xl),
        .i_xr   (w_xr),
        .i_en   (w_inc),
        .o_x    (w_x),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_valid   <= 1'b0;
            r_pix_y      <= '0;
            r_pix_color  <= '0;
            r_cur_y      <= '0;
            r_y_end      <= '0;
            r_fill_done  <= 1'b0;
            r_all_finish <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fill_done <= 1'b0;
                    if (bus.row_start) begin
                        r_cur_y      <= w_y_lo;
                        r_y_end      <= w_y_hi;
                        r_all_finish <= 1'b0;
                    end else if (w_accept_fill) begin
                        r_pix_color <= bus.color;
                        if (w_empty) begin
                            r_fill_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_wr_valid <= 1'b1;
                            r_pix_y    <= r_cur_y;
                            r_state    <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.wr_ready && w_last) begin
                        r_wr_valid  <= 1'b0;
                        r_fill_done <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_fill_done <= 1'b0;
                    r_state     <= ST_IDLE;
                    // The last row is held so cur_y can never run past y_end.
                    if (r_cur_y == r_y_end) begin
                        r_all_finish <= 1'b1;
                    end else begin
                        r_cur_y <= r_cur_y + Y_W'(1);
                    end
                end
                default: begin
                    r_wr_valid  <= 1'b0;
                    r_fill_done <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_valid   = r_wr_valid;
    assign bus.pix_x      = w_x;
    assign bus.pix_y      = r_pix_y;
    assign bus.pix_color  = r_pix_color;
    assign bus.cur_y      = r_cur_y;
    assign bus.fill_done  = r_fill_done;
    assign bus.all_finish = r_all_finish;

endmodule

`default_nettype wire
